// File: rtl/multi_cycle_cpu.sv
// Multi-cycle core for a small LEGv8-style subset (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B).
// One memory port shared by instruction fetch and data access, with a valid/ready handshake.
module multi_cycle_cpu #(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_request,
    output logic                   mem_write,
    output logic [DATA_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    input  logic                   mem_ready,
    output logic [DATA_WIDTH-1:0]  pc,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] retired
);

    if (DATA_WIDTH < 32) begin : g_width_check
        $error("multi_cycle_cpu: DATA_WIDTH must be at least 32");
    end

    typedef enum logic [2:0] {
        StFetch, StDecode, StExecute, StMemory, StWriteback, StHalt
    } state_e;

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOrr, OpLdur, OpStur, OpCbz, OpB
    } op_e;

    state_e                  state_q;
    op_e                     op_q;
    logic [31:0]             ir_q;
    logic [DATA_WIDTH-1:0]   pc_q, a_q, b_q, imm_q, addr_q, res_q;
    logic [COUNT_WIDTH-1:0]  retired_q;
    logic                    halted_q, illegal_q;
    logic [DATA_WIDTH-1:0]   rf_q [32];

    logic                    dec_valid;
    op_e                     dec_op;
    logic [DATA_WIDTH-1:0]   dec_imm;
    logic [4:0]              rn_idx, rm_idx;
    logic [DATA_WIDTH-1:0]   rn_val, rm_val;
    logic [DATA_WIDTH-1:0]   pc_next;

    always_comb begin
        dec_valid = 1'b1;
        dec_op    = OpAdd;
        dec_imm   = '0;
        if (ir_q[31:26] == 6'b000101) begin
            dec_op  = OpB;
            dec_imm = {{(DATA_WIDTH-28){ir_q[25]}}, ir_q[25:0], 2'b00};
        end else if (ir_q[31:24] == 8'b10110100) begin
            dec_op  = OpCbz;
            dec_imm = {{(DATA_WIDTH-21){ir_q[23]}}, ir_q[23:5], 2'b00};
        end else begin
            case (ir_q[31:21])
                11'b10001011000: dec_op = OpAdd;
                11'b11001011000: dec_op = OpSub;
                11'b10001010000: dec_op = OpAnd;
                11'b10101010000: dec_op = OpOrr;
                11'b11111000010: dec_op = OpLdur;
                11'b11111000000: dec_op = OpStur;
                default:         dec_valid = 1'b0;
            endcase
            dec_imm = {{(DATA_WIDTH-9){ir_q[20]}}, ir_q[20:12]};
        end
    end

    // Rt lives in [4:0] for memory and CBZ forms, Rm in [20:16] for R-type.
    assign rn_idx  = ir_q[9:5];
    assign rm_idx  = (dec_op inside {OpLdur, OpStur, OpCbz}) ? ir_q[4:0] : ir_q[20:16];
    assign rn_val  = (rn_idx == 5'd31) ? '0 : rf_q[rn_idx];
    assign rm_val  = (rm_idx == 5'd31) ? '0 : rf_q[rm_idx];
    assign pc_next = pc_q + DATA_WIDTH'(4);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            op_q      <= OpAdd;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            addr_q    <= '0;
            res_q     <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q    <= mem_read_data[31:0];
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (ir_q == 32'h0) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else if (!dec_valid) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
                    end else begin
                        op_q    <= dec_op;
                        a_q     <= rn_val;
                        b_q     <= rm_val;
                        imm_q   <= dec_imm;
                        state_q <= StExecute;
                    end
                end
                StExecute: begin
                    unique case (op_q)
                        OpAdd: begin res_q <= a_q + b_q; state_q <= StWriteback; end
                        OpSub: begin res_q <= a_q - b_q; state_q <= StWriteback; end
                        OpAnd: begin res_q <= a_q & b_q; state_q <= StWriteback; end
                        OpOrr: begin res_q <= a_q | b_q; state_q <= StWriteback; end
                        OpLdur, OpStur: begin
                            addr_q  <= a_q + imm_q;
                            state_q <= StMemory;
                        end
                        OpCbz: begin
                            pc_q      <= (b_q == '0) ? pc_q + imm_q : pc_next;
                            retired_q <= retired_q + COUNT_WIDTH'(1);
                            state_q   <= StFetch;
                        end
                        OpB: begin
                            pc_q      <= pc_q + imm_q;
                            retired_q <= retired_q + COUNT_WIDTH'(1);
                            state_q   <= StFetch;
                        end
                    endcase
                end
                StMemory: begin
                    if (mem_ready) begin
                        if (op_q == OpStur) begin
                            pc_q      <= pc_next;
                            retired_q <= retired_q + COUNT_WIDTH'(1);
                            state_q   <= StFetch;
                        end else begin
                            res_q   <= mem_read_data;
                            state_q <= StWriteback;
                        end
                    end
                end
                StWriteback: begin
                    if (ir_q[4:0] != 5'd31) begin
                        rf_q[ir_q[4:0]] <= res_q;
                    end
                    pc_q      <= pc_next;
                    retired_q <= retired_q + COUNT_WIDTH'(1);
                    state_q   <= StFetch;
                end
                StHalt: ;
                default: state_q <= StHalt;
            endcase
        end
    end

    // Request outputs are gated by reset so a transfer drops the moment reset asserts
    // and the first fetch is presented in the first cycle after release.
    always_comb begin
        mem_request    = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (reset) begin
            if (state_q == StFetch) begin
                mem_request = 1'b1;
                mem_address = pc_q;
            end else if (state_q == StMemory) begin
                mem_request = 1'b1;
                mem_address = addr_q;
                if (op_q == OpStur) begin
                    mem_write      = 1'b1;
                    mem_write_data = b_q;
                end
            end
        end
    end

    assign pc      = pc_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
